// File: rtl/connect_rd_router_if.sv
// AR and R channel bundles shared by the read-return router and its neighbours.

interface connect_rd_router_ar_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  logic              valid;
  logic              ready;
  logic [ID_W-1:0]   id;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              route;   // 1 = AIDC path, 0 = CNN bypass

  modport master (output valid, id, addr, len, route, input ready);
  modport slave  (input valid, id, addr, len, route, output ready);
endinterface

interface connect_rd_router_r_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              valid;
  logic              ready;
  logic [ID_W-1:0]   id;
  logic [DATA_W-1:0] data;
  logic [1:0]        resp;
  logic              last;

  modport master (output valid, id, data, resp, last, input ready);
  modport slave  (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/connect_rd_router.sv
// Read-return router: forwards AR bursts to XHB, remembers each burst's
// origin in an in-order table and steers the returning R beats to the
// AIDC or CNN port, counting beats and flagging protocol errors.

module connect_rd_router #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  connect_rd_router_ar_if.slave     s_ar,
  connect_rd_router_ar_if.master    m_ar,
  connect_rd_router_r_if.slave      m_r,
  connect_rd_router_r_if.master     aidc_r,
  connect_rd_router_r_if.master     cnn_r,
  output logic [$clog2(DEPTH):0]    outstanding_o,
  output logic                      proto_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              tbl_route_q [DEPTH];
  logic              tbl_route_d [DEPTH];
  logic [LEN_W-1:0]  tbl_len_q   [DEPTH];
  logic [LEN_W-1:0]  tbl_len_d   [DEPTH];
  logic [ID_W-1:0]   tbl_id_q    [DEPTH];
  logic [ID_W-1:0]   tbl_id_d    [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic              full, empty;
  logic              head_route;
  logic [LEN_W-1:0]  head_len;
  logic [ID_W-1:0]   head_id;
  logic              push, pop, beat, last_beat, sel_ok;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_route = tbl_route_q[rd_ptr_q];
  assign head_len   = tbl_len_q[rd_ptr_q];
  assign head_id    = tbl_id_q[rd_ptr_q];

  // AR pass-through; fullness is judged on the registered count only, so a
  // same-cycle pop never frees a slot for a push.
  always_comb begin
    m_ar.valid = s_ar.valid & ~full & ~rst;
    s_ar.ready = m_ar.ready & ~full & ~rst;
    m_ar.id    = s_ar.id;
    m_ar.addr  = s_ar.addr;
    m_ar.len   = s_ar.len;
    m_ar.route = s_ar.route;
    push       = s_ar.valid & m_ar.ready & ~full & ~rst;
  end

  // R steering: the head entry picks the destination port and whose ready counts.
  always_comb begin
    sel_ok       = ~empty & ~rst;
    aidc_r.valid = sel_ok &  head_route & m_r.valid;
    cnn_r.valid  = sel_ok & ~head_route & m_r.valid;
    m_r.ready    = sel_ok & (head_route ? aidc_r.ready : cnn_r.ready);
    aidc_r.id    = m_r.id;
    aidc_r.data  = m_r.data;
    aidc_r.resp  = m_r.resp;
    aidc_r.last  = m_r.last;
    cnn_r.id     = m_r.id;
    cnn_r.data   = m_r.data;
    cnn_r.resp   = m_r.resp;
    cnn_r.last   = m_r.last;
    beat         = m_r.valid & m_r.ready;
    last_beat    = (beat_cnt_q == head_len);
    pop          = beat & last_beat;
  end

  // Next-state for the table, pointers, beat counter and error flag.
  always_comb begin
    tbl_route_d = tbl_route_q;
    tbl_len_d   = tbl_len_q;
    tbl_id_d    = tbl_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;

    if (push) begin
      tbl_route_d[wr_ptr_q] = s_ar.route;
      tbl_len_d[wr_ptr_q]   = s_ar.len;
      tbl_id_d[wr_ptr_q]    = s_ar.id;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Completion follows the counted length; rlast only feeds the error check.
    if (beat) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + LEN_W'(1);
      if ((m_r.last != last_beat) || (m_r.id != head_id)) begin
        proto_err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_route_q[i] <= 1'b0;
        tbl_len_q[i]   <= '0;
        tbl_id_q[i]    <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      tbl_route_q <= tbl_route_d;
      tbl_len_q   <= tbl_len_d;
      tbl_id_q    <= tbl_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_connect_rd_router.sv
// Randomized bench for connect_rd_router with a queue-based reference model.

module tb_connect_rd_router;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] outstanding_o;
  logic       proto_err_o;

  always #5 clk = ~clk;

  connect_rd_router_ar_if #(.ADDR_W(32), .ID_W(4), .LEN_W(4)) s_ar ();
  connect_rd_router_ar_if #(.ADDR_W(32), .ID_W(4), .LEN_W(4)) m_ar ();
  connect_rd_router_r_if  #(.DATA_W(32), .ID_W(4)) m_r ();
  connect_rd_router_r_if  #(.DATA_W(32), .ID_W(4)) aidc_r ();
  connect_rd_router_r_if  #(.DATA_W(32), .ID_W(4)) cnn_r ();

  connect_rd_router #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_ar(s_ar), .m_ar(m_ar), .m_r(m_r), .aidc_r(aidc_r), .cnn_r(cnn_r),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  typedef struct packed {
    logic       route;
    logic [3:0] len;
    logic [3:0] id;
  } ent_t;

  ent_t        mq[$];
  int unsigned bc;
  bit          merr;
  int          n_chk = 0;
  int          n_err = 0;

  int ar_p, arr_p, r_p, rdy_a_p, rdy_c_p, err_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare every cycle, then advance on the handshakes.
  always @(negedge clk) begin
    ent_t hd;
    bit   full, empty, e_arv, e_arr, e_av, e_cv, e_rr, lst;
    if (rst) begin
      check("rst_m_arvalid", 64'(m_ar.valid), 64'(0));
      check("rst_s_arready", 64'(s_ar.ready), 64'(0));
      check("rst_m_rready",  64'(m_r.ready),  64'(0));
      check("rst_aidc_rvalid", 64'(aidc_r.valid), 64'(0));
      check("rst_cnn_rvalid",  64'(cnn_r.valid),  64'(0));
      mq.delete();
      bc   = 0;
      merr = 0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      e_arv = s_ar.valid && !full;
      e_arr = m_ar.ready && !full;
      hd    = '0;
      e_av  = 0; e_cv = 0; e_rr = 0;
      if (!empty) begin
        hd   = mq[0];
        e_av = hd.route  && m_r.valid;
        e_cv = !hd.route && m_r.valid;
        e_rr = hd.route ? aidc_r.ready : cnn_r.ready;
      end
      check("m_arvalid", 64'(m_ar.valid), 64'(e_arv));
      check("s_arready", 64'(s_ar.ready), 64'(e_arr));
      check("m_ar_fields", {24'd0, m_ar.id, m_ar.addr, m_ar.len}, {24'd0, s_ar.id, s_ar.addr, s_ar.len});
      check("aidc_rvalid", 64'(aidc_r.valid), 64'(e_av));
      check("cnn_rvalid",  64'(cnn_r.valid),  64'(e_cv));
      check("m_rready",    64'(m_r.ready),    64'(e_rr));
      check("aidc_r_fields", {25'd0, aidc_r.id, aidc_r.data, aidc_r.resp, aidc_r.last},
                             {25'd0, m_r.id, m_r.data, m_r.resp, m_r.last});
      check("cnn_r_fields",  {25'd0, cnn_r.id, cnn_r.data, cnn_r.resp, cnn_r.last},
                             {25'd0, m_r.id, m_r.data, m_r.resp, m_r.last});
      check("outstanding", 64'(outstanding_o), 64'(mq.size()));
      check("proto_err",   64'(proto_err_o),   64'(merr));
      if (e_rr && m_r.valid) begin
        lst = (bc == int'(hd.len));
        if (m_r.last != lst || m_r.id != hd.id) merr = 1;
        if (lst) begin
          void'(mq.pop_front());
          bc = 0;
        end else begin
          bc++;
        end
      end
      if (e_arv && m_ar.ready) mq.push_back('{s_ar.route, s_ar.len, s_ar.id});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input bit v, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input bit route);
    s_ar.valid = v; s_ar.id = id; s_ar.addr = addr; s_ar.len = len; s_ar.route = route;
  endtask

  task automatic drive_r(input bit v, input logic [3:0] id, input logic [31:0] data, input bit last);
    m_r.valid = v; m_r.id = id; m_r.data = data; m_r.resp = 2'b00; m_r.last = last;
  endtask

  // Well-formed beat for the current head burst.
  task automatic drive_head_beat();
    if (mq.size() != 0) drive_r(1, mq[0].id, $urandom, bc == int'(mq[0].len));
    else drive_r(0, 0, 0, 0);
  endtask

  task automatic drain();
    int unsigned n = 0;
    drive_ar(0, 0, 0, 0, 0);
    aidc_r.ready = 1; cnn_r.ready = 1;
    while (mq.size() != 0 && n < 200) begin
      drive_head_beat();
      cycle();
      n++;
    end
    drive_r(0, 0, 0, 0);
    if (mq.size() != 0) check("drain_timeout", 64'(1), 64'(0));
  endtask

  task automatic rand_cycle();
    drive_ar($urandom_range(99) < ar_p, 4'($urandom), $urandom, 4'($urandom_range(3)), 1'($urandom));
    m_ar.ready   = $urandom_range(99) < arr_p;
    aidc_r.ready = $urandom_range(99) < rdy_a_p;
    cnn_r.ready  = $urandom_range(99) < rdy_c_p;
    if (mq.size() != 0 && $urandom_range(99) < r_p) begin
      drive_head_beat();
      if ($urandom_range(99) < err_p) begin
        if ($urandom_range(1) == 0) m_r.last = ~m_r.last;
        else m_r.id = m_r.id + 4'd1;
      end
    end else begin
      drive_r($urandom_range(3) == 0, 4'($urandom), $urandom, 1'($urandom));
    end
    cycle();
  endtask

  initial begin
    drive_ar(0, 0, 0, 0, 0);
    drive_r(0, 0, 0, 0);
    m_ar.ready = 0; aidc_r.ready = 0; cnn_r.ready = 0;
    repeat (3) cycle();
    check("rst_outstanding_lit", 64'(outstanding_o), 64'(0));
    check("rst_proto_err_lit",   64'(proto_err_o),   64'(0));
    rst = 0;

    // Single beat on the AIDC path.
    m_ar.ready = 1; aidc_r.ready = 1; cnn_r.ready = 1;
    drive_ar(1, 4'd3, 32'h100, 4'd0, 1);
    #2 check("t1_m_arvalid_lit", 64'(m_ar.valid), 64'(1));
    cycle();
    drive_ar(0, 0, 0, 0, 0);
    drive_r(1, 4'd3, 32'hDEADBEEF, 1);
    #2;
    check("t1_outstanding1_lit", 64'(outstanding_o), 64'(1));
    check("t1_aidc_rvalid_lit",  64'(aidc_r.valid),  64'(1));
    check("t1_aidc_rdata_lit",   64'(aidc_r.data),   64'(32'hDEADBEEF));
    check("t1_cnn_rvalid_lit",   64'(cnn_r.valid),   64'(0));
    cycle();
    drive_r(0, 0, 0, 0);
    #2;
    check("t1_outstanding0_lit", 64'(outstanding_o), 64'(0));
    check("t1_proto_err_lit",    64'(proto_err_o),   64'(0));

    // Fill the table, then free one slot.
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      drive_ar(1, 4'(i), 32'(i * 16), 4'd0, 1'(i));
    end
    cycle();
    #2;
    check("full_outstanding_lit", 64'(outstanding_o), 64'(8));
    check("full_s_arready_lit",   64'(s_ar.ready),    64'(0));
    check("full_m_arvalid_lit",   64'(m_ar.valid),    64'(0));
    cycle();
    drive_head_beat();
    #2 check("full_pop_s_arready_lit", 64'(s_ar.ready), 64'(0));
    cycle();
    drive_r(0, 0, 0, 0);
    #2;
    check("full_after_pop_outstanding_lit", 64'(outstanding_o), 64'(7));
    check("full_after_pop_s_arready_lit",   64'(s_ar.ready),    64'(1));
    cycle();
    drain();

    // Random traffic without protocol errors.
    err_p = 0;
    for (int seg = 0; seg < 4; seg++) begin
      ar_p = 20 + 20 * seg; arr_p = 50 + 15 * seg; r_p = 90 - 15 * seg;
      rdy_a_p = (seg == 2) ? 30 : 80; rdy_c_p = (seg == 1) ? 30 : 80;
      repeat (500) rand_cycle();
    end
    drain();
    cycle();

    // rlast on the first beat of a 2-beat burst.
    drive_ar(1, 4'd5, 32'h200, 4'd1, 0);
    cycle();
    drive_ar(0, 0, 0, 0, 0);
    drive_r(1, 4'd5, 32'h11, 1);
    cycle();
    drive_r(1, 4'd5, 32'h22, 1);
    #2;
    check("perr_set_lit",        64'(proto_err_o),   64'(1));
    check("perr_outstanding_lit", 64'(outstanding_o), 64'(1));
    cycle();
    drive_r(0, 0, 0, 0);
    #2;
    check("perr_done_lit",   64'(outstanding_o), 64'(0));
    check("perr_sticky_lit", 64'(proto_err_o),   64'(1));

    // Reset in the middle of a 4-beat burst.
    cycle();
    drive_ar(1, 4'd2, 32'h300, 4'd3, 1);
    cycle();
    drive_ar(0, 0, 0, 0, 0);
    drive_r(1, 4'd2, 32'h33, 0);
    cycle();
    drive_ar(1, 4'd4, 32'h400, 4'd0, 1);
    rst = 1;
    #2;
    check("mrst_m_rready_lit",    64'(m_r.ready),    64'(0));
    check("mrst_aidc_rvalid_lit", 64'(aidc_r.valid), 64'(0));
    check("mrst_m_arvalid_lit",   64'(m_ar.valid),   64'(0));
    cycle();
    rst = 0;
    drive_ar(0, 0, 0, 0, 0);
    drive_r(0, 0, 0, 0);
    #2;
    check("mrst_outstanding_lit", 64'(outstanding_o), 64'(0));
    check("mrst_proto_err_lit",   64'(proto_err_o),   64'(0));
    cycle();
    drive_ar(1, 4'd7, 32'h500, 4'd0, 0);
    cycle();
    drive_ar(0, 0, 0, 0, 0);
    drive_r(1, 4'd7, 32'h12345678, 1);
    #2;
    check("mrst_cnn_rvalid_lit",  64'(cnn_r.valid),  64'(1));
    check("mrst_cnn_rdata_lit",   64'(cnn_r.data),   64'(32'h12345678));
    check("mrst_aidc_rvalid0_lit", 64'(aidc_r.valid), 64'(0));
    cycle();
    drive_r(0, 0, 0, 0);

    // Random traffic with occasional malformed beats.
    ar_p = 50; arr_p = 70; r_p = 70; rdy_a_p = 70; rdy_c_p = 70; err_p = 2;
    repeat (1000) rand_cycle();
    drain();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/connect_rd_router.md
Name: connect_rd_router

Overview:
- Read-return stage between CONNECT's muxed AR/R path and the XHB slave.
- Forwards each AR burst to XHB and records in an in-order table whether the burst came through the AIDC path or the CNN-engine bypass path.
- Steers the returning R beats to the AIDC port or the CNN port, counting beats per burst and flagging protocol errors.
- XHB returns read bursts strictly in AR-issue order.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
ID_W, 4, AXI ID width
LEN_W, 4, ARLEN width (beats = arlen+1)
DEPTH, 8, outstanding-burst table depth; power of two, >=2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
s_arvalid  in  1  AR request from CONNECT
s_arready  out  1  AR accepted
s_arid  in  ID_W  AR ID
s_araddr  in  ADDR_W  AR address
s_arlen  in  LEN_W  AR burst length minus one
s_arroute  in  1  1=AIDC path burst, 0=CNN bypass burst
m_arvalid  out  1  AR to XHB
m_arready  in  1  XHB AR ready
m_arid / m_araddr / m_arlen  out  ID_W / ADDR_W / LEN_W  forwarded AR fields
m_rvalid  in  1  R beat from XHB
m_rready  out  1  R accepted
m_rid / m_rdata / m_rresp / m_rlast  in  ID_W / DATA_W / 2 / 1  R fields
aidc_rvalid  out  1  R beat to AIDC
aidc_rready  in  1
aidc_rid / aidc_rdata / aidc_rresp / aidc_rlast  out  ID_W / DATA_W / 2 / 1
cnn_rvalid  out  1  R beat to CNN engine
cnn_rready  in  1
cnn_rid / cnn_rdata / cnn_rresp / cnn_rlast  out  ID_W / DATA_W / 2 / 1
outstanding_o  out  $clog2(DEPTH)+1  bursts issued, not yet completed
proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync release): table empty, wr/rd pointers 0, count 0, beat_cnt 0, proto_err_o 0. While rst=1, all valid/ready outputs are forced to 0; data outputs are don't-care.
- full = (count==DEPTH); empty = (count==0). Both are derived from registered count only.
- AR path, zero latency, combinational:
  - m_arvalid = s_arvalid & !full
  - s_arready = m_arready & !full
  - m_ar* fields equal s_ar* fields
  - Push {arroute, arlen, arid} into the table on m_arvalid & m_arready.
- Full: AR is stalled even when a pop occurs in the same cycle; the slot is usable the next cycle.
- R path, zero latency:
  - When empty: m_rready=0, aidc_rvalid=cnn_rvalid=0.
  - Otherwise the head entry selects the port. For head.route=1: aidc_rvalid=m_rvalid, m_rready=aidc_rready, cnn_rvalid=0. For route=0 the roles mirror.
  - r fields are passed through unchanged to both ports.
- Beat handshake = m_rvalid & m_rready. On each beat:
  - If beat_cnt==head.len: pop the head, beat_cnt←0.
  - Else beat_cnt←beat_cnt+1.
  - Burst completion follows the counted length, not m_rlast.
- proto_err_o is set, and held until reset, when a beat has:
  - m_rlast != (beat_cnt==head.len), or
  - m_rid != head.id.
  - The beat is still delivered.
- m_rvalid while the table is empty is ignored: not accepted, no error.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- outstanding_o = count.
- Reset mid-burst: the table and beat counter are discarded; XHB is reset on the same rst.
- Backpressure: the non-selected port's ready is ignored. A stalled head port blocks all later returns (in-order).

Test Plan:
- Single-beat routing: AR(id=3, len=0, route=1, addr=0x100); XHB returns one beat, data=0xDEADBEEF, rlast=1 -> aidc_rvalid=1 with data 0xDEADBEEF; cnn_rvalid=0 throughout; outstanding_o 1→0; proto_err_o=0.
- Interleaved routes: AR len=3 route=0, then AR len=1 route=1; XHB returns 6 beats back-to-back -> first 4 beats on cnn, last 2 on aidc; cnn_rlast on beat 4, aidc_rlast on beat 6.
- Full table: issue 8 ARs with R held off -> outstanding_o=8, 9th AR sees s_arready=0 and m_arvalid=0. Complete one burst -> s_arready returns 1 the cycle after the pop.
- Backpressure: route=1 burst len=2, aidc_rready toggling 1,0,1,0,1 and cnn_rready=1 -> m_rready tracks aidc_rready; exactly 3 beats accepted; beat_cnt not advanced on stalled cycles.
- Protocol error: burst len=1 with m_rlast=1 on beat 0 -> proto_err_o=1 from the next cycle; burst still completes after 2 beats; flag remains set until rst.
- Reset mid-burst: rst asserted after 1 of 4 beats -> all valids and readies 0 immediately; after release outstanding_o=0, proto_err_o=0; a new AR/R burst routes correctly.
